hdr_ddr_rx_deserializer: RTL and testbench

Controller-side HDR-DDR receive stage for the I3C controller. Samples SDA on every SCL edge strobe from the SCL generator, frames preamble, data, parity and CRC words, and delivers checked 16-bit words to the CCC handler and regfile write path. It sits between the SDA handling/SCL generation blocks and the CCC handler. It is enabled for the span in which the CCC handler asserts its rx enable.

---
 rtl/hdr_ddr_pkg.sv | 31 +++
 rtl/hdr_ddr_rx_deserializer_if.sv | 31 +++
 rtl/hdr_ddr_rx_deserializer_crc5_calc.sv | 36 +++
 rtl/hdr_ddr_rx_deserializer.sv | 203 ++++++++++++++++++++
 tb/tb_hdr_ddr_rx_deserializer.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdr_ddr_pkg.sv
// Shared HDR-DDR receive definitions: FSM states, framing constants and the
// two-bit DDR word parity.
package hdr_ddr_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_PARITY,
    ST_CHECK,
    ST_CRC_TOKEN,
    ST_CRC_VALUE,
    ST_DONE,
    ST_ABORT
  } rx_state_e;

  localparam logic [1:0] PRE_DATA  = 2'b10;
  localparam logic [1:0] PRE_CRC   = 2'b01;
  localparam logic [3:0] CRC_TOKEN = 4'hC;
  localparam logic [4:0] CRC5_SEED = 5'b11111;
  localparam logic [4:0] CRC5_POLY = 5'b00101;

  // PA1 covers the odd bit positions, PA0 the even positions inverted.
  function automatic logic [1:0] ddr_parity(input logic [15:0] d);
    logic [1:0] p;
    p[1] = ^(d & 16'hAAAA);
    p[0] = ~^(d & 16'h5555);
    return p;
  endfunction

endpackage

// File: rtl/hdr_ddr_rx_deserializer_if.sv
// Bus between the SDA/SCL front end, the CCC handler and the HDR-DDR
// receive deserializer. The deserializer uses the slave modport.
interface hdr_ddr_rx_deserializer_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
);
  logic              i_rx_en;
  logic              i_scl_pos_edge;
  logic              i_scl_neg_edge;
  logic              i_sda;
  logic [DATA_W-1:0] o_word;
  logic              o_word_valid;
  logic [1:0]        o_preamble;
  logic              o_parity_err;
  logic              o_crc_err;
  logic              o_abort;
  logic              o_rx_done;
  logic [CNT_W-1:0]  o_word_cnt;

  modport master (
    output i_rx_en, i_scl_pos_edge, i_scl_neg_edge, i_sda,
    input  o_word, o_word_valid, o_preamble, o_parity_err, o_crc_err,
           o_abort, o_rx_done, o_word_cnt
  );

  modport slave (
    input  i_rx_en, i_scl_pos_edge, i_scl_neg_edge, i_sda,
    output o_word, o_word_valid, o_preamble, o_parity_err, o_crc_err,
           o_abort, o_rx_done, o_word_cnt
  );
endinterface

// File: rtl/hdr_ddr_rx_deserializer_crc5_calc.sv
// Serial CRC5 (x^5+x^2+1), MSB-first, one bit per enable; reseeded on init.
module crc5_calc
  import hdr_ddr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_init,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [4:0] o_crc
);

  logic [4:0] crc_q, crc_d;
  logic       fb;

  always_comb begin
    fb    = crc_q[4] ^ i_bit;
    crc_d = crc_q;
    if (i_init) begin
      crc_d = CRC5_SEED;
    end else if (i_en) begin
      crc_d = {crc_q[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'b00000);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= CRC5_SEED;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign o_crc = crc_q;

endmodule

// File: rtl/hdr_ddr_rx_deserializer.sv
// HDR-DDR receive deserializer: frames preamble/data/parity/CRC words from SDA
// sampled on SCL edge strobes. Define HDR_DDR_RX_CRC_CHECK_EN for CRC5 checking.
module hdr_ddr_rx_deserializer
  import hdr_ddr_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int CRC_W     = 5,
  parameter int MAX_WORDS = 8
) (
  input  logic                     i_sdr_clk,
  input  logic                     i_sdr_rst,
  hdr_ddr_rx_deserializer_if.slave rx
);

  localparam int CNT_W = $clog2(MAX_WORDS + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [BIT_W-1:0] PAIR_LAST = BIT_W'(1);
  localparam logic [BIT_W-1:0] TOK_LAST  = BIT_W'(3);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] CRC_LAST  = BIT_W'(CRC_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_WORDS);

  rx_state_e         state_q, state_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [1:0]        pre_q, pre_d;
  logic              perr_q, perr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rx_en_q, rx_en_d;

  logic              strobe;
  logic              rx_rise;
  logic              collecting;
  logic [DATA_W-1:0] sh_shift;

`ifdef HDR_DDR_RX_CRC_CHECK_EN
  logic       crcerr_q, crcerr_d;
  logic       crc_en;
  logic [4:0] crc_val;

  crc5_calc u_crc5_calc (
    .clk    (i_sdr_clk),
    .rst    (i_sdr_rst),
    .i_init (rx_rise),
    .i_en   (crc_en),
    .i_bit  (rx.i_sda),
    .o_crc  (crc_val)
  );
`endif

  always_comb begin
    strobe     = rx.i_scl_pos_edge | rx.i_scl_neg_edge;
    rx_rise    = rx.i_rx_en & ~rx_en_q;
    sh_shift   = {sh_q[DATA_W-2:0], rx.i_sda};
    collecting = (state_q == ST_PREAMBLE) || (state_q == ST_DATA) ||
                 (state_q == ST_PARITY) || (state_q == ST_CRC_TOKEN) ||
                 (state_q == ST_CRC_VALUE);

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    data_d    = data_q;
    word_d    = word_q;
    pre_d     = pre_q;
    perr_d    = perr_q;
    cnt_d     = cnt_q;
    rx_en_d   = rx.i_rx_en;
`ifdef HDR_DDR_RX_CRC_CHECK_EN
    crcerr_d  = crcerr_q;
    crc_en    = 1'b0;
`endif

    if (collecting && strobe) begin
      sh_d      = sh_shift;
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    // Each field transitions on the strobe that delivers its last bit.
    unique case (state_q)
      ST_IDLE: begin
        if (rx.i_rx_en) state_d = ST_PREAMBLE;
      end
      ST_PREAMBLE: begin
        if (strobe && bit_cnt_q == PAIR_LAST) begin
          bit_cnt_d = '0;
          pre_d     = sh_shift[1:0];
          if (sh_shift[1:0] == PRE_DATA) begin
            state_d = (cnt_q == CNT_MAX) ? ST_ABORT : ST_DATA;
          end else if (sh_shift[1:0] == PRE_CRC) begin
            state_d = ST_CRC_TOKEN;
          end else begin
            state_d = ST_ABORT;
          end
        end
      end
      ST_DATA: begin
        if (strobe) begin
`ifdef HDR_DDR_RX_CRC_CHECK_EN
          crc_en = 1'b1;
`endif
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            data_d    = sh_shift;
            state_d   = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (strobe && bit_cnt_q == PAIR_LAST) begin
          bit_cnt_d = '0;
          word_d    = data_q;
          if (sh_shift[1:0] != ddr_parity(data_q)) perr_d = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          state_d   = ST_CHECK;
        end
      end
      ST_CHECK: state_d = ST_PREAMBLE;
      ST_CRC_TOKEN: begin
        if (strobe && bit_cnt_q == TOK_LAST) begin
          bit_cnt_d = '0;
          state_d   = (sh_shift[3:0] == CRC_TOKEN) ? ST_CRC_VALUE : ST_ABORT;
        end
      end
      ST_CRC_VALUE: begin
        if (strobe && bit_cnt_q == CRC_LAST) begin
          bit_cnt_d = '0;
          state_d   = ST_DONE;
`ifdef HDR_DDR_RX_CRC_CHECK_EN
          if (sh_shift[CRC_W-1:0] != crc_val) crcerr_d = 1'b1;
`endif
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    if (rx_rise) begin
      perr_d = 1'b0;
      cnt_d  = '0;
`ifdef HDR_DDR_RX_CRC_CHECK_EN
      crcerr_d = 1'b0;
`endif
    end

    // Losing the enable drops the frame silently.
    if (!rx.i_rx_en) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sh_d      = '0;
    end
  end

  always_ff @(posedge i_sdr_clk or posedge i_sdr_rst) begin
    if (i_sdr_rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      word_q    <= '0;
      pre_q     <= '0;
      perr_q    <= 1'b0;
      cnt_q     <= '0;
      rx_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      word_q    <= word_d;
      pre_q     <= pre_d;
      perr_q    <= perr_d;
      cnt_q     <= cnt_d;
      rx_en_q   <= rx_en_d;
    end
  end

`ifdef HDR_DDR_RX_CRC_CHECK_EN
  always_ff @(posedge i_sdr_clk or posedge i_sdr_rst) begin
    if (i_sdr_rst) begin
      crcerr_q <= 1'b0;
    end else begin
      crcerr_q <= crcerr_d;
    end
  end

  assign rx.o_crc_err = crcerr_q;
`else
  assign rx.o_crc_err = 1'b0;
`endif

  assign rx.o_word       = word_q;
  assign rx.o_word_valid = (state_q == ST_CHECK);
  assign rx.o_preamble   = pre_q;
  assign rx.o_parity_err = perr_q;
  assign rx.o_abort      = (state_q == ST_ABORT);
  assign rx.o_rx_done    = (state_q == ST_DONE);
  assign rx.o_word_cnt   = cnt_q;

endmodule

// File: tb/tb_hdr_ddr_rx_deserializer.sv
// Scoreboard bench for hdr_ddr_rx_deserializer: stimulus queues expected
// events and status checks, a negedge monitor compares them against the DUT.
module tb_hdr_ddr_rx_deserializer;

  localparam int K_WORD  = 0;
  localparam int K_ABORT = 1;
  localparam int K_DONE  = 2;

  localparam int S_WORD   = 0;
  localparam int S_PERR   = 1;
  localparam int S_CRCERR = 2;
  localparam int S_CNT    = 3;
  localparam int S_PRE    = 4;
  localparam int S_VALID  = 5;
  localparam int S_ABORT  = 6;
  localparam int S_DONE   = 7;
  localparam int S_QLEN   = 8;

  typedef struct {
    int          kind;
    logic [15:0] word;
  } ev_t;

  typedef struct {
    int          sig;
    logic [31:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tog = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  ev_t  exp_q[$];
  chk_t chk_q[$];

  hdr_ddr_rx_deserializer_if #(.DATA_W(16), .CNT_W(4)) rx_if ();

  hdr_ddr_rx_deserializer #(.DATA_W(16), .CRC_W(5), .MAX_WORDS(8)) dut (
    .i_sdr_clk (clk),
    .i_sdr_rst (rst),
    .rx        (rx_if)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  function automatic string sig_name(input int s);
    case (s)
      S_WORD:   return "o_word";
      S_PERR:   return "o_parity_err";
      S_CRCERR: return "o_crc_err";
      S_CNT:    return "o_word_cnt";
      S_PRE:    return "o_preamble";
      S_VALID:  return "o_word_valid";
      S_ABORT:  return "o_abort";
      S_DONE:   return "o_rx_done";
      default:  return "pending_events";
    endcase
  endfunction

  function automatic logic [1:0] ddr_par(input logic [15:0] w);
    return {^(w & 16'hAAAA), ~^(w & 16'h5555)};
  endfunction

  function automatic logic [4:0] crc5_model(input logic [4:0] c, input logic [15:0] w);
    logic [4:0] r;
    logic       fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[4] ^ w[i];
      r  = {r[3:0], 1'b0};
      if (fb) r = r ^ 5'h05;
    end
    return r;
  endfunction

  // Monitor: pops expected events on every output pulse and services checks.
  always @(negedge clk) begin : monitor
    ev_t         e;
    chk_t        c;
    int          k;
    logic [31:0] a;
    if (rx_if.i_scl_pos_edge && rx_if.i_scl_neg_edge) begin
      n_fail++;
      $display("FAIL both_strobes actual=1 required=0");
    end
    if (rx_if.o_word_valid || rx_if.o_abort || rx_if.o_rx_done) begin
      k = rx_if.o_word_valid ? K_WORD : (rx_if.o_abort ? K_ABORT : K_DONE);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event actual_kind=%0d required=none", k);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != k) begin
          n_fail++;
          $display("FAIL event_kind actual=%0d required=%0d", k, e.kind);
        end else if (k == K_WORD) begin
          n_cmp++;
          if (rx_if.o_word !== e.word) begin
            n_fail++;
            $display("FAIL word_data actual=%h required=%h", rx_if.o_word, e.word);
          end
        end
      end
    end
    while (chk_q.size() != 0) begin
      c = chk_q.pop_front();
      case (c.sig)
        S_WORD:   a = {16'h0, rx_if.o_word};
        S_PERR:   a = {31'h0, rx_if.o_parity_err};
        S_CRCERR: a = {31'h0, rx_if.o_crc_err};
        S_CNT:    a = {28'h0, rx_if.o_word_cnt};
        S_PRE:    a = {30'h0, rx_if.o_preamble};
        S_VALID:  a = {31'h0, rx_if.o_word_valid};
        S_ABORT:  a = {31'h0, rx_if.o_abort};
        S_DONE:   a = {31'h0, rx_if.o_rx_done};
        default:  a = exp_q.size();
      endcase
      n_cmp++;
      if (a !== c.exp) begin
        n_fail++;
        $display("FAIL %s actual=%0h required=%0h", sig_name(c.sig), a, c.exp);
      end
    end
  end

  task automatic req(input int sig, input logic [31:0] exp);
    chk_t c;
    c.sig = sig;
    c.exp = exp;
    chk_q.push_back(c);
  endtask

  task automatic expect_ev(input int kind, input logic [15:0] w);
    ev_t e;
    e.kind = kind;
    e.word = w;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bit per strobe, alternating SCL edges, with a quiet cycle between.
  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    rx_if.i_sda = b;
    if (tog) rx_if.i_scl_neg_edge = 1'b1;
    else     rx_if.i_scl_pos_edge = 1'b1;
    tog = ~tog;
    @(posedge clk); #1;
    rx_if.i_scl_pos_edge = 1'b0;
    rx_if.i_scl_neg_edge = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_word(input logic [15:0] w, input logic [1:0] par);
    expect_ev(K_WORD, w);
    send_bits(16'b10, 2);
    send_bits(w, 16);
    send_bits({14'h0, par}, 2);
  endtask

  task automatic send_crc(input logic [4:0] crc);
    expect_ev(K_DONE, 16'h0);
    send_bits(16'b01, 2);
    send_bits(16'hC, 4);
    send_bits({11'h0, crc}, 5);
    idle(3);
  endtask

  task automatic new_frame();
    @(posedge clk); #1;
    rx_if.i_rx_en = 1'b0;
    idle(2);
    rx_if.i_rx_en = 1'b1;
    idle(2);
  endtask

  logic [15:0] words8 [8];
  logic [4:0]  crc_good;
  logic        crc_flip_exp;

  initial begin
    words8[0] = 16'h0001; words8[1] = 16'h8000; words8[2] = 16'hFFFF; words8[3] = 16'h0000;
    words8[4] = 16'h1357; words8[5] = 16'hC0DE; words8[6] = 16'h7E7E; words8[7] = 16'h5AA5;
`ifdef HDR_DDR_RX_CRC_CHECK_EN
    crc_flip_exp = 1'b1;
`else
    crc_flip_exp = 1'b0;
`endif
    rx_if.i_rx_en = 1'b0;
    rx_if.i_scl_pos_edge = 1'b0;
    rx_if.i_scl_neg_edge = 1'b0;
    rx_if.i_sda = 1'b0;

    // Reset state
    idle(2);
    req(S_WORD, 0); req(S_VALID, 0); req(S_PRE, 0); req(S_PERR, 0);
    req(S_CRCERR, 0); req(S_ABORT, 0); req(S_DONE, 0); req(S_CNT, 0);
    idle(1);
    rst = 1'b0;
    idle(2);

    // Good word, bad-parity word, then sticky parity error
    rx_if.i_rx_en = 1'b1;
    idle(2);
    send_word(16'hA55A, 2'b01);
    req(S_PERR, 0); req(S_CNT, 1); req(S_PRE, 2'b10);
    send_word(16'hA55A, 2'b11);
    req(S_PERR, 1); req(S_CNT, 2);
    send_word(16'h0F0F, ddr_par(16'h0F0F));
    req(S_PERR, 1); req(S_CNT, 3);

    // Illegal preambles and bad CRC token
    expect_ev(K_ABORT, 16'h0);
    send_bits(16'b11, 2);
    idle(3);
    req(S_PRE, 2'b11); req(S_CNT, 3); req(S_WORD, 16'h0F0F);
    expect_ev(K_ABORT, 16'h0);
    send_bits(16'b01, 2);
    send_bits(16'hA, 4);
    idle(3);
    expect_ev(K_ABORT, 16'h0);
    send_bits(16'b00, 2);
    idle(3);

    // CRC frame with correct checksum
    new_frame();
    req(S_PERR, 0); req(S_CNT, 0);
    crc_good = crc5_model(crc5_model(5'h1F, 16'h1234), 16'hBEEF);
    send_word(16'h1234, ddr_par(16'h1234));
    send_word(16'hBEEF, ddr_par(16'hBEEF));
    send_crc(crc_good);
    req(S_CRCERR, 0); req(S_CNT, 2); req(S_PRE, 2'b01); req(S_PERR, 0);

    // CRC frame with one CRC bit flipped
    new_frame();
    send_word(16'h1234, ddr_par(16'h1234));
    send_word(16'hBEEF, ddr_par(16'hBEEF));
    send_crc(crc_good ^ 5'b00100);
    req(S_CRCERR, {31'h0, crc_flip_exp});

    // Enable dropped after 9 data bits, then a clean word
    new_frame();
    req(S_CRCERR, 0);
    send_bits(16'b10, 2);
    send_bits(16'h01FF, 9);
    rx_if.i_rx_en = 1'b0;
    idle(4);
    req(S_QLEN, 0); req(S_CNT, 0);
    rx_if.i_rx_en = 1'b1;
    idle(2);
    send_word(16'h3C96, ddr_par(16'h3C96));
    req(S_CNT, 1); req(S_PERR, 0);

    // Eight words fill the frame; a ninth data preamble aborts
    new_frame();
    for (int i = 0; i < 8; i++) send_word(words8[i], ddr_par(words8[i]));
    req(S_CNT, 8);
    expect_ev(K_ABORT, 16'h0);
    send_bits(16'b10, 2);
    idle(3);
    req(S_CNT, 8); req(S_PERR, 0); req(S_WORD, 16'h5AA5);

    // Asynchronous reset in the middle of a word
    new_frame();
    send_bits(16'b10, 2);
    send_bits(16'h0015, 5);
    rst = 1'b1;
    #1;
    req(S_WORD, 0); req(S_VALID, 0); req(S_PRE, 0); req(S_PERR, 0);
    req(S_CRCERR, 0); req(S_ABORT, 0); req(S_DONE, 0); req(S_CNT, 0);
    @(negedge clk);
    @(posedge clk); #1;
    rx_if.i_rx_en = 1'b0;
    rst = 1'b0;
    idle(3);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    req(S_QLEN, 0);
    @(negedge clk);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
